// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide over WIDTH iterations, sign fix-up in one extra cycle.
// Ports:
//   clk, reset         - clock and synchronous active-high reset
//   Start              - begin an operation (accepted in IDLE or DONE)
//   Funct3             - M-extension op select (MUL..REMU)
//   SrcA, SrcB         - rs1 / rs2 operands
//   Busy               - stall request while computing (CALC, FIX)
//   Done               - one-cycle pulse, Result valid
//   Result             - registered result, held until next load or reset
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     ma_q, ma_d;
    logic [WIDTH-1:0]     mb_q, mb_d;
    logic                 sa_q, sa_d;
    logic                 sb_q, sb_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     res_q, res_d;

    logic                 a_signed, b_signed;
    logic                 neg_a, neg_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       trial;
    logic [WIDTH-1:0]     diff;
    logic                 ge;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     remv;
    logic                 b_zero;

    assign a_signed = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                      (Funct3 == 3'b100) || (Funct3 == 3'b110);
    assign b_signed = (Funct3 == 3'b001) || (Funct3 == 3'b100) ||
                      (Funct3 == 3'b110);
    assign neg_a = a_signed & SrcA[WIDTH-1];
    assign neg_b = b_signed & SrcB[WIDTH-1];
    assign mag_a = neg_a ? -SrcA : SrcA;
    assign mag_b = neg_b ? -SrcB : SrcB;

    // Multiply: low half holds the multiplier, shifted out LSB first;
    // the multiplicand is added into the high half with carry.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                     (acc_q[0] ? {1'b0, ma_q} : {(WIDTH+1){1'b0}});

    // Divide: low half of acc holds the dividend, shifted out MSB first,
    // while quotient bits shift in at the bottom.
    assign trial = {rem_q, acc_q[WIDTH-1]};
    assign ge    = (trial >= {1'b0, mb_q});
    // When ge holds the difference is below the divisor, so W bits suffice.
    assign diff  = trial[WIDTH-1:0] - mb_q;

    // Sign flags are zero for unsigned operands, so no op decode is needed.
    assign prod   = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign quo    = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign remv   = sa_q ? -rem_q : rem_q;
    assign b_zero = (mb_q == '0);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        res_d   = res_q;
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    op_d    = Funct3;
                    a_d     = SrcA;
                    ma_d    = mag_a;
                    mb_d    = mag_b;
                    sa_d    = neg_a;
                    sb_d    = neg_b;
                    cnt_d   = '0;
                    acc_d   = {{WIDTH{1'b0}}, Funct3[2] ? mag_a : mag_b};
                    rem_d   = '0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (op_q[2]) begin
                    rem_d = ge ? diff : trial[WIDTH-1:0];
                    acc_d = {acc_q[2*WIDTH-1:WIDTH],
                             acc_q[WIDTH-2:0], ge};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                case (op_q)
                    3'b000:                 res_d = prod[WIDTH-1:0];
                    3'b001, 3'b010, 3'b011: res_d = prod[2*WIDTH-1:WIDTH];
                    3'b100, 3'b101:         res_d = b_zero ? '1 : quo;
                    default:                res_d = b_zero ? a_q : remv;
                endcase
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
        end
    end

    assign Busy   = (state_q == CALC) || (state_q == FIX);
    assign Done   = (state_q == DONE);
    assign Result = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed M-extension cases,
// hold/back-to-back, mid-operation reset and random ops.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         Start;
    logic [2:0]   Funct3;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Result;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [W-1:0] exp_q[$];
    string        name_q[$];

    muldiv_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .Start  (Start),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .Busy   (Busy),
        .Done   (Done),
        .Result (Result)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [W-1:0] act,
                         input logic [W-1:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", nm, act, req);
    endtask

    // Reference: plain 64-bit arithmetic following the RV32M rules.
    function automatic logic [W-1:0] model(input logic [2:0] f,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return '1;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 0) return '1;
                p = ua / ub;
                return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every Done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!reset && Done) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_done: got Done=1 Result %h, expected no Done",
                         Result);
            end else begin
                check(name_q.pop_front(), Result, exp_q.pop_front());
            end
        end
    end

    // Called at a negedge; returns at the negedge of the Done cycle.
    task automatic run_op(input string nm, input logic [2:0] f,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hold);
        int cyc;
        int busy_n;
        bit got;
        Start  = 1'b1;
        Funct3 = f;
        SrcA   = a;
        SrcB   = b;
        exp_q.push_back(model(f, a, b));
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        if (!hold) Start = 1'b0;
        cyc    = 0;
        busy_n = 0;
        got    = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (Done) begin
                got = 1'b1;
            end else begin
                if (Busy) busy_n++;
                if (hold) begin
                    SrcA   = $urandom;
                    SrcB   = $urandom;
                    Funct3 = 3'($urandom);
                end
            end
        end
        Start = 1'b0;
        check({nm, "_done_cycle"}, W'(cyc), W'(W + 2));
        check({nm, "_busy_cycles"}, W'(busy_n), W'(W + 1));
        check({nm, "_busy_at_done"}, W'(Busy), W'(0));
    endtask

    initial begin
        int dn;
        reset  = 1'b1;
        Start  = 1'b0;
        Funct3 = '0;
        SrcA   = '0;
        SrcB   = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", W'(Busy), W'(0));
        check("rst_done", W'(Done), W'(0));
        check("rst_result", Result, W'(0));
        reset = 1'b0;
        @(negedge clk);

        run_op("mul_7", 3'd0, 32'd7, 32'hFFFFFFFD, 1'b0);
        @(negedge clk);
        run_op("mulh_min", 3'd1, 32'h80000000, 32'h80000000, 1'b0);
        run_op("mulhu_ff", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op("mulhsu_ff", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op("div_m7", 3'd4, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_op("rem_m7", 3'd6, 32'hFFFFFFF9, 32'd2, 1'b0);
        @(negedge clk);
        run_op("divu_100", 3'd5, 32'd100, 32'd7, 1'b0);
        run_op("remu_100", 3'd7, 32'd100, 32'd7, 1'b0);
        run_op("div_by0", 3'd4, 32'd5, 32'd0, 1'b0);
        run_op("rem_by0", 3'd6, 32'd5, 32'd0, 1'b0);
        run_op("divu_by0", 3'd5, 32'hFFFFFFF0, 32'd0, 1'b0);
        run_op("remu_by0", 3'd7, 32'hFFFFFFF0, 32'd0, 1'b0);
        run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0);

        @(negedge clk);
        run_op("hold_mulhu", 3'd3, 32'h12345678, 32'h9ABCDEF0, 1'b1);
        run_op("b2b_divu", 3'd5, 32'd9, 32'd3, 1'b0);

        @(negedge clk);
        Start  = 1'b1;
        Funct3 = 3'd0;
        SrcA   = 32'd123457;
        SrcB   = 32'd99;
        @(posedge clk);
        #1;
        Start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", W'(Busy), W'(0));
        check("abort_done", W'(Done), W'(0));
        check("abort_result", Result, W'(0));
        reset = 1'b0;
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done) dn++;
        end
        check("abort_no_done", W'(dn), W'(0));
        run_op("mul_3x4", 3'd0, 32'd3, 32'd4, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            run_op($sformatf("rnd%0d", i), 3'($urandom), pick(), pick(),
                   bit'($urandom_range(0, 3) == 0));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", W'(exp_q.size()), W'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
